// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit CPU with illegal-opcode and
// memory-timeout trap plus retired-instruction counter. Strobes are registered Moore decodes.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 4,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                instr_ready,
  input  logic                mem_ready,
  input  logic                alu_zero,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg_dst,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                trap,
  output logic                trap_cause,
  output logic [CNT_W-1:0]    retired
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [2:0] {K_R, K_I, K_LW, K_SW, K_BEQ, K_ILL} kind_t;

  typedef struct packed {
    logic               instr_ready;
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
    logic               trap;
    logic               trap_cause;
  } ctl_t;

  function automatic kind_t kind_of(input logic [OPCODE_W-1:0] op);
    kind_t k;
    case (op)
      OPCODE_W'(4'h0), OPCODE_W'(4'h2), OPCODE_W'(4'h3), OPCODE_W'(4'h4),
      OPCODE_W'(4'hC), OPCODE_W'(4'h6), OPCODE_W'(4'h7): k = K_R;
      OPCODE_W'(4'h5), OPCODE_W'(4'hD), OPCODE_W'(4'h1): k = K_I;
      OPCODE_W'(4'h8):                                   k = K_LW;
      OPCODE_W'(4'h9):                                   k = K_SW;
      OPCODE_W'(4'hF):                                   k = K_BEQ;
      default:                                           k = K_ILL;
    endcase
    return k;
  endfunction

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                cause_q, cause_d;
  ctl_t                ctl_q, ctl_d;
  kind_t               cur_kind, nxt_kind;
  logic                br_taken;

  assign cur_kind = kind_of(opcode_q);
  assign nxt_kind = kind_of(opcode_d);

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    cause_d   = cause_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH: begin
        if (instr_valid) begin
          opcode_d = opcode;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cur_kind == K_ILL) begin
          state_d = S_TRAP;
          cause_d = 1'b0;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wait_d = '0;
        case (cur_kind)
          K_LW, K_SW: state_d = S_MEM;
          K_BEQ: begin
            state_d   = S_FETCH;
            retired_d = retired_q + CNT_W'(1);
          end
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        // mem_ready in the final wait cycle takes priority over the timeout
        if (mem_ready) begin
          if (cur_kind == K_SW) begin
            state_d   = S_FETCH;
            retired_d = retired_q + CNT_W'(1);
          end else begin
            state_d = S_WB;
          end
        end else if (MEM_TIMEOUT != 0 && wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        state_d   = S_FETCH;
        retired_d = retired_q + CNT_W'(1);
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_RESET;
    endcase
  end

  // Decode the upcoming state so the strobes come straight out of flops
  always_comb begin
    ctl_d = '0;
    case (state_d)
      S_FETCH: ctl_d.instr_ready = 1'b1;
      S_EXEC: begin
        ctl_d.reg_dst = (nxt_kind == K_R);
        ctl_d.alu_src = (nxt_kind == K_I) || (nxt_kind == K_LW) || (nxt_kind == K_SW);
        ctl_d.branch  = (nxt_kind == K_BEQ);
        case (nxt_kind)
          K_R:     ctl_d.alu_op = ALUOP_W'(2'b10);
          K_I:     ctl_d.alu_op = ALUOP_W'(2'b11);
          K_BEQ:   ctl_d.alu_op = ALUOP_W'(2'b01);
          default: ctl_d.alu_op = ALUOP_W'(2'b00);
        endcase
      end
      S_MEM: begin
        ctl_d.mem_read  = (nxt_kind == K_LW);
        ctl_d.mem_write = (nxt_kind == K_SW);
      end
      S_WB: begin
        ctl_d.reg_write  = 1'b1;
        ctl_d.mem_to_reg = (nxt_kind == K_LW);
      end
      S_TRAP: begin
        ctl_d.trap       = 1'b1;
        ctl_d.trap_cause = cause_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      opcode_q  <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      cause_q   <= 1'b0;
      ctl_q     <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
      ctl_q     <= ctl_d;
    end
  end

  // Fetch handshake and branch resolution depend on same-cycle inputs
  assign br_taken = (state_q == S_EXEC) && (cur_kind == K_BEQ) && alu_zero;
  assign ir_write = (state_q == S_FETCH) && instr_valid;
  assign pc_write = ir_write || br_taken;
  assign pc_src   = br_taken;

  assign instr_ready = ctl_q.instr_ready;
  assign reg_dst     = ctl_q.reg_dst;
  assign alu_src     = ctl_q.alu_src;
  assign mem_to_reg  = ctl_q.mem_to_reg;
  assign reg_write   = ctl_q.reg_write;
  assign mem_read    = ctl_q.mem_read;
  assign mem_write   = ctl_q.mem_write;
  assign branch      = ctl_q.branch;
  assign alu_op      = ctl_q.alu_op;
  assign trap        = ctl_q.trap;
  assign trap_cause  = ctl_q.trap_cause;
  assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Cycle-level scoreboard bench: default instance, a wait-forever instance and a 4-bit counter
// instance share one stimulus stream; each queued step carries its inputs and expected outputs.
module tb_multicycle_control_unit;

  localparam logic [14:0] RDY  = 15'h4000, IRW = 15'h2000, PCW = 15'h1000, PCS  = 15'h0800;
  localparam logic [14:0] RDST = 15'h0400, ASRC = 15'h0200, M2R = 15'h0100, RW  = 15'h0080;
  localparam logic [14:0] MR   = 15'h0040, MW   = 15'h0020, BR  = 15'h0010;
  localparam logic [14:0] OP_R = 15'h0008, OP_I = 15'h000C, OP_C = 15'h0004;
  localparam logic [14:0] TRP  = 15'h0002, TCS  = 15'h0001;

  typedef struct {
    bit          rst_n;
    bit          iv;
    logic [3:0]  op;
    bit          mr;
    bit          az;
    logic [14:0] e;
    logic [14:0] e_nt;
    bit          cc;
    logic [15:0] ret;
  } step_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0, instr_valid = 1'b0, mem_ready = 1'b0, alu_zero = 1'b0;
  logic [3:0] opcode = 4'h0;

  logic instr_ready [3], ir_write [3], pc_write [3], pc_src [3], reg_dst [3], alu_src [3];
  logic mem_to_reg [3], reg_write [3], mem_read [3], mem_write [3], branch [3], trap [3];
  logic trap_cause [3];
  logic [1:0]  alu_op [3];
  logic [15:0] ret0, ret1;
  logic [3:0]  ret2;

  step_t sbq[$];
  int    exp_ret = 0;
  int    n_checks = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(instr_ready[0]), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .ir_write(ir_write[0]), .pc_write(pc_write[0]), .pc_src(pc_src[0]), .reg_dst(reg_dst[0]),
    .alu_src(alu_src[0]), .mem_to_reg(mem_to_reg[0]), .reg_write(reg_write[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .branch(branch[0]), .alu_op(alu_op[0]),
    .trap(trap[0]), .trap_cause(trap_cause[0]), .retired(ret0));

  multicycle_control_unit #(.MEM_TIMEOUT(0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(instr_ready[1]), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .ir_write(ir_write[1]), .pc_write(pc_write[1]), .pc_src(pc_src[1]), .reg_dst(reg_dst[1]),
    .alu_src(alu_src[1]), .mem_to_reg(mem_to_reg[1]), .reg_write(reg_write[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .branch(branch[1]), .alu_op(alu_op[1]),
    .trap(trap[1]), .trap_cause(trap_cause[1]), .retired(ret1));

  multicycle_control_unit #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(instr_ready[2]), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .ir_write(ir_write[2]), .pc_write(pc_write[2]), .pc_src(pc_src[2]), .reg_dst(reg_dst[2]),
    .alu_src(alu_src[2]), .mem_to_reg(mem_to_reg[2]), .reg_write(reg_write[2]),
    .mem_read(mem_read[2]), .mem_write(mem_write[2]), .branch(branch[2]), .alu_op(alu_op[2]),
    .trap(trap[2]), .trap_cause(trap_cause[2]), .retired(ret2));

  function automatic logic [14:0] ctl_of(input int i);
    return {instr_ready[i], ir_write[i], pc_write[i], pc_src[i], reg_dst[i], alu_src[i],
            mem_to_reg[i], reg_write[i], mem_read[i], mem_write[i], branch[i], alu_op[i],
            trap[i], trap_cause[i]};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] ro();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, act, exp);
    end
  endtask

  task automatic push(input bit r, input bit iv, input logic [3:0] op, input bit mr,
                      input bit az, input logic [14:0] e, input logic [14:0] e_nt, input bit cc);
    step_t s;
    s.rst_n = r; s.iv = iv; s.op = op; s.mr = mr; s.az = az;
    s.e = e; s.e_nt = e_nt; s.cc = cc; s.ret = 16'(exp_ret);
    sbq.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1, 0, ro(), rb(), rb(), RDY, RDY, 1);
  endtask

  task automatic do_reset(input logic [14:0] eb, input logic [14:0] eb_nt, input bit cb);
    push(0, rb(), ro(), rb(), rb(), eb, eb_nt, cb);
    exp_ret = 0;
    push(0, rb(), ro(), rb(), rb(), 15'h0, 15'h0, 1);
    push(1, rb(), ro(), rb(), rb(), 15'h0, 15'h0, 1);
  endtask

  // One instruction from FETCH accept; opcode input is scrambled outside FETCH
  task automatic issue(input logic [3:0] op, input int waits, input bit az);
    push(1, 1, op, rb(), rb(), RDY | IRW | PCW, RDY | IRW | PCW, 1);
    push(1, 0, ro(), rb(), rb(), 15'h0, 15'h0, 1);
    case (op)
      4'h0, 4'h2, 4'h3, 4'h4, 4'hC, 4'h6, 4'h7: begin
        push(1, 0, ro(), rb(), rb(), RDST | OP_R, RDST | OP_R, 1);
        push(1, 0, ro(), rb(), rb(), RW, RW, 1);
        exp_ret++;
      end
      4'h5, 4'hD, 4'h1: begin
        push(1, 0, ro(), rb(), rb(), ASRC | OP_I, ASRC | OP_I, 1);
        push(1, 0, ro(), rb(), rb(), RW, RW, 1);
        exp_ret++;
      end
      4'h8: begin
        push(1, 0, ro(), rb(), rb(), ASRC, ASRC, 1);
        for (int i = 0; i <= waits; i++) push(1, 0, ro(), i == waits, rb(), MR, MR, 1);
        push(1, 0, ro(), rb(), rb(), RW | M2R, RW | M2R, 1);
        exp_ret++;
      end
      4'h9: begin
        push(1, 0, ro(), rb(), rb(), ASRC, ASRC, 1);
        for (int i = 0; i <= waits; i++) push(1, 0, ro(), i == waits, rb(), MW, MW, 1);
        exp_ret++;
      end
      4'hF: begin
        push(1, 0, ro(), rb(), az, BR | OP_C | (az ? (PCW | PCS) : 15'h0),
             BR | OP_C | (az ? (PCW | PCS) : 15'h0), 1);
        exp_ret++;
      end
      default: begin
        for (int i = 0; i < 3; i++) push(1, 1, ro(), rb(), rb(), TRP, TRP, 1);
      end
    endcase
  endtask

  task automatic drain();
    step_t s;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      @(posedge clk);
      #1;
      rst_n = s.rst_n; instr_valid = s.iv; opcode = s.op; mem_ready = s.mr; alu_zero = s.az;
      @(negedge clk);
      if (s.cc) begin
        check("ctl", 32'(ctl_of(0)), 32'(s.e));
        check("ctl_nt", 32'(ctl_of(1)), 32'(s.e_nt));
        check("ctl_c4", 32'(ctl_of(2)), 32'(s.e));
        check("retired", 32'(ret0), 32'(s.ret));
        check("retired_nt", 32'(ret1), 32'(s.ret));
        check("retired_c4", 32'(ret2), 32'(s.ret[3:0]));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1);
  end

  initial begin
    logic [3:0] ops [11];
    ops = '{4'h0, 4'h2, 4'h3, 4'hC, 4'h6, 4'h7, 4'h5, 4'hD, 4'h1, 4'h9, 4'h8};

    do_reset(15'h0, 15'h0, 0);
    idle(2);
    issue(4'h4, 0, 0);
    issue(4'h8, 3, 0);
    issue(4'hF, 0, 1);
    issue(4'hF, 0, 0);
    foreach (ops[i]) issue(ops[i], i % 3, 0);
    idle(1);
    drain();

    issue(4'hA, 0, 0);
    do_reset(TRP, TRP, 1);
    issue(4'hB, 0, 0);
    do_reset(TRP, TRP, 1);
    issue(4'h4, 0, 0);
    issue(4'hE, 0, 0);
    do_reset(TRP, TRP, 1);
    drain();

    // SW that never completes: default instance traps, wait-forever instance keeps waiting
    issue(4'h4, 0, 0);
    push(1, 1, 4'h9, rb(), rb(), RDY | IRW | PCW, RDY | IRW | PCW, 1);
    push(1, 0, ro(), rb(), rb(), 15'h0, 15'h0, 1);
    push(1, 0, ro(), rb(), rb(), ASRC, ASRC, 1);
    for (int i = 0; i < 15; i++) push(1, 0, ro(), 0, rb(), MW, MW, 1);
    for (int i = 0; i < 4; i++) push(1, 0, ro(), 0, rb(), TRP | TCS, MW, 1);
    do_reset(TRP | TCS, MW, 1);
    drain();

    // Reset in the middle of a load's MEM phase
    issue(4'h5, 0, 0);
    push(1, 1, 4'h8, rb(), rb(), RDY | IRW | PCW, RDY | IRW | PCW, 1);
    push(1, 0, ro(), rb(), rb(), 15'h0, 15'h0, 1);
    push(1, 0, ro(), rb(), rb(), ASRC, ASRC, 1);
    push(1, 0, ro(), 0, rb(), MR, MR, 1);
    push(1, 0, ro(), 0, rb(), MR, MR, 1);
    do_reset(MR, MR, 1);
    for (int i = 0; i < 16; i++) issue(4'h4, 0, 0);
    idle(1);
    issue(4'h4, 0, 0);
    idle(1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
